// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between the WB stage (A, fixed priority) and a
// FIFO-buffered multi-cycle unit (B). Optional macro RF_WB_ARB_STALL_CNT_EN enables stall_cnt_o.
module rf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        a_we_i,
    input  logic [4:0]  a_wr_i,
    input  logic [31:0] a_wd_i,
    input  logic        b_valid_i,
    input  logic [4:0]  b_wr_i,
    input  logic [31:0] b_wd_i,
    output logic        b_ready_o,
    input  logic [4:0]  rR1_i,
    input  logic [4:0]  rR2_i,
    output logic        busy1_o,
    output logic        busy2_o,
    output logic        a_stall_o,
    output logic        WE_o,
    output logic [4:0]  wR_o,
    output logic [31:0] wD_o,
    output logic [31:0] stall_cnt_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [4:0]       entWr [DEPTH];
    logic [31:0]      entWd [DEPTH];
    logic [DEPTH-1:0] entValid;
    logic [DEPTH-1:0] validNext;
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic [PW:0]      count;
    logic [3:0]       starveCnt;
    logic             aStall;
    logic             full;
    logic             aEff;
    logic             headValid;
    logic             headMatch;
    logic             pop;
    logic             push;
    logic             busy1Raw;
    logic             busy2Raw;

    // A stalled slot ignores the WB request entirely; x0 writes are dropped.
    assign full      = (count == (PW+1)'(DEPTH));
    assign aEff      = a_we_i & ~aStall & (a_wr_i != 5'd0);
    assign headValid = (count != (PW+1)'(0)) & entValid[rdPtr];
    assign headMatch = (entWr[rdPtr] == a_wr_i);
    // Head leaves when it drains, or when it is dead (superseded earlier or right now).
    assign pop       = (count != (PW+1)'(0)) & (~aEff | ~headValid | headMatch);
    assign b_ready_o = ~reset_i & ~full;
    assign push      = b_valid_i & b_ready_o & (b_wr_i != 5'd0);
    assign a_stall_o = aStall;

    // Next-cycle entry validity: supersede by A, clear on pop, set on push.
    always_comb begin
        validNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            validNext[i] = (entValid[i] & ~(aEff & (entWr[i] == a_wr_i))
                                        & ~(pop & (rdPtr == PW'(i))))
                         | (push & (wrPtr == PW'(i)));
        end
    end

    // Pending-write scoreboard lookup for the decode stage.
    always_comb begin
        busy1Raw = 1'b0;
        busy2Raw = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy1Raw = busy1Raw | (entValid[i] & (entWr[i] == rR1_i));
            busy2Raw = busy2Raw | (entValid[i] & (entWr[i] == rR2_i));
        end
        busy1_o = busy1Raw & (rR1_i != 5'd0) & ~reset_i;
        busy2_o = busy2Raw & (rR2_i != 5'd0) & ~reset_i;
    end

    // Write-port mux: A first, then the FIFO head.
    always_comb begin
        WE_o = 1'b0;
        wR_o = 5'd0;
        wD_o = 32'd0;
        if (reset_i) begin
            WE_o = 1'b0;
        end else if (aEff) begin
            WE_o = 1'b1;
            wR_o = a_wr_i;
            wD_o = a_wd_i;
        end else if (headValid) begin
            WE_o = 1'b1;
            wR_o = entWr[rdPtr];
            wD_o = entWd[rdPtr];
        end else begin
            WE_o = 1'b0;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            entValid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entWr[i] <= 5'd0;
                entWd[i] <= 32'd0;
            end
        end else begin
            entValid <= validNext;
            if (push) begin
                entWr[wrPtr] <= b_wr_i;
                entWd[wrPtr] <= b_wd_i;
                wrPtr        <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Starvation guard: after STARVE_LIMIT blocked cycles, steal one slot from A.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            starveCnt <= 4'd0;
            aStall    <= 1'b0;
        end else if ((count == (PW+1)'(0)) || pop) begin
            starveCnt <= 4'd0;
            aStall    <= 1'b0;
        end else if (headValid && aEff) begin
            if (starveCnt + 4'd1 == STARVE_MAX) begin
                starveCnt <= 4'd0;
                aStall    <= 1'b1;
            end else begin
                starveCnt <= starveCnt + 4'd1;
                aStall    <= 1'b0;
            end
        end else begin
            starveCnt <= starveCnt;
            aStall    <= 1'b0;
        end
    end

`ifdef RF_WB_ARB_STALL_CNT_EN
    logic [31:0] stallCnt;

    // Counts cycles B is held off by a full FIFO.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stallCnt <= 32'd0;
        end else if (b_valid_i && !b_ready_o) begin
            stallCnt <= stallCnt + 32'd1;
        end else begin
            stallCnt <= stallCnt;
        end
    end
    assign stall_cnt_o = stallCnt;
`else
    assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_rf_wb_arbiter;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        a_we_i;
    logic [4:0]  a_wr_i;
    logic [31:0] a_wd_i;
    logic        b_valid_i;
    logic [4:0]  b_wr_i;
    logic [31:0] b_wd_i;
    logic        b_ready_o;
    logic [4:0]  rR1_i;
    logic [4:0]  rR2_i;
    logic        busy1_o;
    logic        busy2_o;
    logic        a_stall_o;
    logic        WE_o;
    logic [4:0]  wR_o;
    logic [31:0] wD_o;
    logic [31:0] stall_cnt_o;

    int vecCnt = 0;
    int errCnt = 0;

`ifdef RF_WB_ARB_STALL_CNT_EN
    localparam logic [31:0] REFUSED_EXP = 32'd1;
`else
    localparam logic [31:0] REFUSED_EXP = 32'd0;
`endif

    rf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .a_we_i(a_we_i), .a_wr_i(a_wr_i), .a_wd_i(a_wd_i),
        .b_valid_i(b_valid_i), .b_wr_i(b_wr_i), .b_wd_i(b_wd_i), .b_ready_o(b_ready_o),
        .rR1_i(rR1_i), .rR2_i(rR2_i), .busy1_o(busy1_o), .busy2_o(busy2_o),
        .a_stall_o(a_stall_o), .WE_o(WE_o), .wR_o(wR_o), .wD_o(wD_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic aWe, input logic [4:0] aWr, input logic [31:0] aWd,
                         input logic bV, input logic [4:0] bWr, input logic [31:0] bWd);
        a_we_i    = aWe;
        a_wr_i    = aWr;
        a_wd_i    = aWd;
        b_valid_i = bV;
        b_wr_i    = bWr;
        b_wd_i    = bWd;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        rR1_i   = 5'd0;
        rR2_i   = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        checkVal("rst_we", WE_o, 32'd0);
        checkVal("rst_ready", b_ready_o, 32'd0);
        checkVal("rst_stall", a_stall_o, 32'd0);
        checkVal("rst_scnt", stall_cnt_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;

        // B only: one-cycle latency, busy only while pending
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        rR1_i = 5'd5;
        #1;
        checkVal("b_ready", b_ready_o, 32'd1);
        checkVal("b_we0", WE_o, 32'd0);
        checkVal("b_busy_pre", busy1_o, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        checkVal("b_we", WE_o, 32'd1);
        checkVal("b_wr", wR_o, 32'd5);
        checkVal("b_wd", wD_o, 32'hDEADBEEF);
        checkVal("b_busy", busy1_o, 32'd1);
        tick();
        #1;
        checkVal("b_we_after", WE_o, 32'd0);
        checkVal("b_busy_after", busy1_o, 32'd0);

        // Priority, full refusal and starvation drain
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA0);
        rR1_i = 5'd10;
        rR2_i = 5'd11;
        #1;
        checkVal("p1_ready", b_ready_o, 32'd1);
        checkVal("p1_wr", wR_o, 32'd3);
        checkVal("p1_wd", wD_o, 32'h33);
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'hA1);
        #1;
        checkVal("p2_ready", b_ready_o, 32'd1);
        checkVal("p2_wr", wR_o, 32'd3);
        checkVal("p2_busy1", busy1_o, 32'd1);
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hA2);
        #1;
        checkVal("p3_ready", b_ready_o, 32'd0);
        checkVal("p3_busy2", busy2_o, 32'd1);
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        #1;
        checkVal("p4_stall", a_stall_o, 32'd0);
        tick();
        #1;
        checkVal("p5_stall", a_stall_o, 32'd0);
        checkVal("p5_wr", wR_o, 32'd3);
        tick();
        #1;
        checkVal("st_stall", a_stall_o, 32'd1);
        checkVal("st_we", WE_o, 32'd1);
        checkVal("st_wr", wR_o, 32'd10);
        checkVal("st_wd", wD_o, 32'hA0);
        tick();
        #1;
        checkVal("st_release", a_stall_o, 32'd0);
        checkVal("st_a_wr", wR_o, 32'd3);
        checkVal("scnt", stall_cnt_o, REFUSED_EXP);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        checkVal("d_wr", wR_o, 32'd11);
        checkVal("d_wd", wD_o, 32'hA1);
        tick();
        #1;
        checkVal("d_empty_we", WE_o, 32'd0);
        checkVal("d_empty_ready", b_ready_o, 32'd1);

        // Supersede: A overwrites the pending r4 entry
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd1);
        rR1_i = 5'd4;
        #1;
        tick();
        drive(1'b1, 5'd4, 32'd2, 1'b0, 5'd0, 32'd0);
        #1;
        checkVal("sup_we", WE_o, 32'd1);
        checkVal("sup_wd", wD_o, 32'd2);
        checkVal("sup_busy", busy1_o, 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        checkVal("sup_idle_we", WE_o, 32'd0);
        checkVal("sup_idle_busy", busy1_o, 32'd0);

        // x0 handling on both sides
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
        rR1_i = 5'd0;
        #1;
        checkVal("x0_ready", b_ready_o, 32'd1);
        tick();
        drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
        #1;
        checkVal("x0_b_dropped", WE_o, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66);
        #1;
        tick();
        drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
        #1;
        checkVal("x0_head_we", WE_o, 32'd1);
        checkVal("x0_head_wr", wR_o, 32'd6);
        checkVal("x0_head_wd", wD_o, 32'h66);
        tick();

        // Reset mid-operation with two queued entries
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd20, 32'hB0);
        rR1_i = 5'd20;
        rR2_i = 5'd21;
        #1;
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd21, 32'hB1);
        #1;
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        #1;
        checkVal("mr_busy1", busy1_o, 32'd1);
        checkVal("mr_busy2", busy2_o, 32'd1);
        #1 reset_i = 1'b1;
        #1;
        checkVal("mr_we", WE_o, 32'd0);
        checkVal("mr_busy1_rst", busy1_o, 32'd0);
        checkVal("mr_busy2_rst", busy2_o, 32'd0);
        checkVal("mr_ready_rst", b_ready_o, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        #2 reset_i = 1'b0;
        #1;
        checkVal("mr_ready", b_ready_o, 32'd1);
        checkVal("mr_we_after", WE_o, 32'd0);
        checkVal("mr_busy_after", busy1_o, 32'd0);
        checkVal("mr_scnt", stall_cnt_o, 32'd0);
        tick();
        #1;
        checkVal("mr_empty_we", WE_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (wR/wD/WE) between two writers.
- Requester A is the pipeline WB stage: fixed priority, no handshake.
- Requester B is the multi-cycle unit (mul/div): valid/ready handshake, writes buffered in a DEPTH-entry FIFO.
- Sits between WB/multi-cycle unit and the reg_file write inputs; also reports pending-write hits to the hazard/stall logic.

Parameters:
- DEPTH, 2, B-side FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 4, cycles a valid FIFO head may wait before forcing a drain slot (1..15).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-high.
- a_we_i  in  1  WB write enable.
- a_wr_i  in  5  WB destination register.
- a_wd_i  in  32  WB write data.
- b_valid_i  in  1  multi-cycle result valid.
- b_wr_i  in  5  multi-cycle destination register.
- b_wd_i  in  32  multi-cycle data.
- b_ready_o  out  1  FIFO can accept.
- rR1_i  in  5  decode read address 1.
- rR2_i  in  5  decode read address 2.
- busy1_o  out  1  rR1_i matches a valid FIFO entry.
- busy2_o  out  1  rR2_i matches a valid FIFO entry.
- a_stall_o  out  1  registered; forced-drain slot, WB must hold.
- WE_o  out  1  to reg_file WE_i.
- wR_o  out  5  to reg_file wR_i.
- wD_o  out  32  to reg_file wD_i.
- stall_cnt_o  out  32  B backpressure cycle count (optional feature).

Behaviour:
- Reset (async): FIFO empty, pointers/count/starve counter = 0, a_stall_o = 0, stall_cnt_o = 0.
- While reset_i is high: b_ready_o = 0, busy1_o/busy2_o = 0, WE_o = 0, wR_o = 0, wD_o = 0.
- b_ready_o = !full (combinational from count); accept on b_valid_i & b_ready_o.
- B writes with b_wr_i == 0 complete the handshake but are not enqueued.
- A effective = a_we_i & !a_stall_o & (a_wr_i != 0).
  - A effective: WE_o = 1, wR_o = a_wr_i, wD_o = a_wd_i (combinational, 0-cycle latency).
  - In the same cycle, every valid FIFO entry with wr == a_wr_i is invalidated (A is newer). An invalidated head is popped without a write.
- A not effective and FIFO head valid: WE_o = 1, wR_o/wD_o = head fields; head pops this edge.
- Otherwise: WE_o = 0, wR_o = 0, wD_o = 0.
- Minimum B latency: 1 cycle (enqueue edge → drain cycle).
- Full FIFO with simultaneous pop and push: the push is still refused (b_ready_o depends on count only).
- Pointer wrap: modulo DEPTH; count range 0..DEPTH.
- Starve counter:
  - Increments each cycle the head is valid and A is effective.
  - Clears on a head pop or when the FIFO is empty.
  - At STARVE_LIMIT: a_stall_o = 1 next cycle for exactly one cycle, then the counter clears.
  - While a_stall_o = 1: A inputs are ignored (no write, no invalidation); the head drains. The pipeline re-presents the WB write next cycle.
- busy1_o/busy2_o: combinational compare against valid entries. Address 0 is never busy. An entry draining this cycle still reports busy.

Optional Feature:
- Macro RF_WB_ARB_STALL_CNT_EN.
- Defined: stall_cnt_o increments (wrapping at 2^32) every cycle b_valid_i & !b_ready_o; cleared only by reset.
- Undefined: counter logic absent; stall_cnt_o tied to 32'h0.

Test Plan:
- Reset mid-operation: two B entries queued, reset_i pulsed mid-cycle → immediately WE_o = 0, busy1_o/busy2_o = 0. After release, b_ready_o = 1 and count = 0.
- B only: b_wr_i = 5, b_wd_i = 32'hDEADBEEF accepted at edge N → cycle N+1: WE_o = 1, wR_o = 5, wD_o = 32'hDEADBEEF; busy1_o = 1 for rR1_i = 5 during cycle N+1 only.
- Priority / full: A writes r3 every cycle; three B pushes (DEPTH = 2) → third push sees b_ready_o = 0. With the macro defined, stall_cnt_o counts each refused cycle.
- Starvation: A continuously writing r7, FIFO head r9 → after 4 cycles a_stall_o = 1 for one cycle, that cycle WE_o = 1, wR_o = 9; the r7 write of that cycle is not performed.
- Supersede: FIFO holds r4 = 1; A writes r4 = 2 → WE_o = 1, wD_o = 2; r4 entry dropped; the next idle cycle has WE_o = 0.
- x0 handling: b_wr_i = 0 handshake completes, count unchanged. a_wr_i = 0 with a_we_i = 1 → WE_o driven from the FIFO head, or 0 if the FIFO is empty.
